// File: rtl/flash_cmd_pkg.sv
// Intel CUI command words, status-register bit layout and FSM state encoding
// shared by the NOR flash program/erase engine.
package flash_cmd_pkg;

    localparam logic [15:0] CMD_PROGRAM    = 16'h0040;
    localparam logic [15:0] CMD_ERASE      = 16'h0020;
    localparam logic [15:0] CMD_CONFIRM    = 16'h00D0;
    localparam logic [15:0] CMD_CLR_SR     = 16'h0050;
    localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;

    // SR7 = write state machine ready; SR5/4/3/1 = erase, program, VPEN, lock errors
    localparam int         SR_READY    = 7;
    localparam logic [7:0] SR_ERR_MASK = 8'h3A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_CMD_R,
        ST_DATA,
        ST_DATA_R,
        ST_POLL,
        ST_SAMPLE,
        ST_CLR,
        ST_CLR_R,
        ST_RDA,
        ST_RDA_R
    } state_t;

endpackage

// File: rtl/flash_phase_div.sv
// Bus-phase timebase: ticks once every 2**STEP_W clocks; restart realigns the
// phase so the first command phase after an accept has full length.
module flash_phase_div #(
    parameter int STEP_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    logic [STEP_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (restart)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = &cnt;

endmodule

// File: rtl/flash_prog_ctrl.sv
// NOR flash program/erase engine: command/data bus cycles, status polling, SR
// clear on error, return to read-array. Erase support is built with FLASH_ERASE_EN.
module flash_prog_ctrl
    import flash_cmd_pkg::*;
#(
    parameter int          STEP_W   = 2,
    parameter logic [19:0] POLL_MAX = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] addr,
    input  logic [15:0] wdata,
    input  logic        prog_req,
    input  logic        erase_req,
    inout  wire  [15:0] flash_data,
    output logic [22:0] flash_addr,
    output logic        flash_byte,
    output logic        flash_vpen,
    output logic        flash_ce,
    output logic        flash_rp,
    output logic        flash_oe,
    output logic        flash_we,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  sr_out
);

    state_t      state, state_d;
    logic        phase_tick;
    logic        accept;
    logic [15:0] wdata_q;
    logic [15:0] first_word, second_word;
    logic [19:0] poll_cnt;
    logic        set_err, latch_sr, poll_inc;
    logic        oe_d, we_d, dq_en_d, dq_en_q;
    logic [15:0] dq_d, dq_q;
    logic [7:0]  sr_in, dq_hi_unused;

    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b1;
    assign flash_ce   = 1'b0;
    assign flash_rp   = 1'b1;

    assign flash_data   = dq_en_q ? dq_q : 16'hzzzz;
    assign sr_in        = flash_data[7:0];
    assign dq_hi_unused = flash_data[15:8];
    assign busy         = (state != ST_IDLE);

`ifdef FLASH_ERASE_EN
    logic op_erase_q, op_erase_d;

    assign accept     = (state == ST_IDLE) && (prog_req || erase_req);
    // program wins when both requests arrive together
    assign op_erase_d = accept ? !prog_req : op_erase_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            op_erase_q <= 1'b0;
        else
            op_erase_q <= op_erase_d;
    end

    assign first_word  = op_erase_d ? CMD_ERASE : CMD_PROGRAM;
    assign second_word = op_erase_q ? CMD_CONFIRM : wdata_q;
`else
    logic erase_unused;

    assign erase_unused = erase_req;
    assign accept       = (state == ST_IDLE) && prog_req;
    assign first_word   = CMD_PROGRAM;
    assign second_word  = wdata_q;
`endif

    flash_phase_div #(.STEP_W(STEP_W)) u_div (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (phase_tick)
    );

    always_comb begin
        state_d  = state;
        set_err  = 1'b0;
        latch_sr = 1'b0;
        poll_inc = 1'b0;
        case (state)
            ST_IDLE:   if (accept)     state_d = ST_CMD;
            ST_CMD:    if (phase_tick) state_d = ST_CMD_R;
            ST_CMD_R:  if (phase_tick) state_d = ST_DATA;
            ST_DATA:   if (phase_tick) state_d = ST_DATA_R;
            ST_DATA_R: if (phase_tick) state_d = ST_POLL;
            ST_POLL:   if (phase_tick) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (phase_tick) begin
                    latch_sr = 1'b1;
                    if (!sr_in[SR_READY]) begin
                        if (poll_cnt == POLL_MAX) begin
                            state_d = ST_CLR;
                            set_err = 1'b1;
                        end else begin
                            state_d  = ST_POLL;
                            poll_inc = 1'b1;
                        end
                    end else if (|(sr_in & SR_ERR_MASK)) begin
                        state_d = ST_CLR;
                        set_err = 1'b1;
                    end else begin
                        state_d = ST_RDA;
                    end
                end
            end
            ST_CLR:    if (phase_tick) state_d = ST_CLR_R;
            ST_CLR_R:  if (phase_tick) state_d = ST_RDA;
            ST_RDA:    if (phase_tick) state_d = ST_RDA_R;
            ST_RDA_R:  if (phase_tick) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Pin levels are decoded from the next state and registered, so the pins
    // change on the same edge as the state and never glitch.
    always_comb begin
        oe_d    = 1'b1;
        we_d    = 1'b1;
        dq_en_d = 1'b0;
        dq_d    = dq_q;
        case (state_d)
            ST_CMD:    begin we_d = 1'b0; dq_en_d = 1'b1; dq_d = first_word;     end
            ST_CMD_R:  begin              dq_en_d = 1'b1; dq_d = first_word;     end
            ST_DATA:   begin we_d = 1'b0; dq_en_d = 1'b1; dq_d = second_word;    end
            ST_DATA_R: begin              dq_en_d = 1'b1; dq_d = second_word;    end
            ST_POLL:                      oe_d = 1'b0;
            ST_SAMPLE:                    oe_d = 1'b0;
            ST_CLR:    begin we_d = 1'b0; dq_en_d = 1'b1; dq_d = CMD_CLR_SR;     end
            ST_CLR_R:  begin              dq_en_d = 1'b1; dq_d = CMD_CLR_SR;     end
            ST_RDA:    begin we_d = 1'b0; dq_en_d = 1'b1; dq_d = CMD_READ_ARRAY; end
            ST_RDA_R:  begin              dq_en_d = 1'b1; dq_d = CMD_READ_ARRAY; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            flash_oe   <= 1'b1;
            flash_we   <= 1'b1;
            dq_en_q    <= 1'b0;
            flash_addr <= '0;
            poll_cnt   <= '0;
            error      <= 1'b0;
            sr_out     <= '0;
            done       <= 1'b0;
        end else begin
            state    <= state_d;
            flash_oe <= oe_d;
            flash_we <= we_d;
            dq_en_q  <= dq_en_d;
            done     <= (state == ST_RDA_R) && phase_tick;
            if (accept) begin
                flash_addr <= {addr, 1'b0};
                poll_cnt   <= '0;
                error      <= 1'b0;
            end else begin
                if (poll_inc)
                    poll_cnt <= poll_cnt + 1'b1;
                if (set_err)
                    error <= 1'b1;
            end
            if (latch_sr)
                sr_out <= sr_in;
        end
    end

    always_ff @(posedge clk) begin
        dq_q <= dq_d;
        if (accept)
            wdata_q <= wdata;
    end

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Directed bench for flash_prog_ctrl with a status-register flash model and a
// write-cycle scoreboard; erase steps follow FLASH_ERASE_EN.
module tb_flash_prog_ctrl;

    typedef struct packed {
        logic [22:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [21:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        prog_req = 1'b0;
    logic        erase_req = 1'b0;
    wire  [15:0] flash_data;
    logic [22:0] flash_addr;
    logic        flash_byte, flash_vpen, flash_ce, flash_rp;
    logic        flash_oe, flash_we, busy, done, error;
    logic [7:0]  sr_out;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    int  oe_cnt = 0;
    int  oe_base = 0;
    int  ready_after = 0;
    logic [7:0] sr_final = 8'h80;
    int  done_cnt = 0;
    logic prev_we = 1'b1;
    wire [7:0] model_sr;

    always #5 clk = ~clk;

    flash_prog_ctrl #(.STEP_W(2), .POLL_MAX(20'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .prog_req   (prog_req),
        .erase_req  (erase_req),
        .flash_data (flash_data),
        .flash_addr (flash_addr),
        .flash_byte (flash_byte),
        .flash_vpen (flash_vpen),
        .flash_ce   (flash_ce),
        .flash_rp   (flash_rp),
        .flash_oe   (flash_oe),
        .flash_we   (flash_we),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .sr_out     (sr_out)
    );

    // Flash model: status reads busy until ready_after output-enabled cycles elapse
    assign model_sr   = ((oe_cnt - oe_base) >= ready_after) ? sr_final : 8'h00;
    assign flash_data = (!flash_oe) ? {8'h00, model_sr} : 16'hzzzz;

    always @(posedge clk)
        if (!flash_oe) oe_cnt <= oe_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each completed write cycle (WE rising) is popped and compared
    always @(negedge clk) begin
        wr_t e;
        prev_we <= flash_we;
        if (done) done_cnt <= done_cnt + 1;
        if (rst) begin
            chk("oe_we_exclusive", {30'd0, flash_oe, flash_we} == 32'd0 ? 32'd0 : 32'd1, 32'd1);
            if (!prev_we && flash_we) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_write observed=%0h expected=none", flash_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_data", {16'd0, flash_data}, {16'd0, e.d});
                    chk("wr_addr", {9'd0, flash_addr}, {9'd0, e.a});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic push_seq(input logic [21:0] a, input logic [15:0] w0, input logic [15:0] w1,
                            input bit with_clr);
        exp_q.push_back('{a: {a, 1'b0}, d: w0});
        exp_q.push_back('{a: {a, 1'b0}, d: w1});
        if (with_clr) exp_q.push_back('{a: {a, 1'b0}, d: 16'h0050});
        exp_q.push_back('{a: {a, 1'b0}, d: 16'h00FF});
    endtask

    task automatic start_req(input logic [21:0] a, input logic [15:0] d, input bit p, input bit e);
        @(negedge clk);
        addr = a; wdata = d; prog_req = p; erase_req = e;
        oe_base = oe_cnt;
        @(negedge clk);
        prog_req = 1'b0; erase_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        @(negedge clk);
        chk({tag, "_done_single"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int dc;
        int n;
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_oe", {31'd0, flash_oe}, 32'd1);
        chk("rst_we", {31'd0, flash_we}, 32'd1);
        chk("rst_addr", {9'd0, flash_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_sr", {24'd0, sr_out}, 32'd0);
        chk("const_pins", {28'd0, flash_byte, flash_vpen, flash_ce, flash_rp}, 32'hD);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Program, ready on the fourth status sample; a second request mid-op is ignored
        sr_final = 8'h80; ready_after = 3 * 8 + 4;
        push_seq(22'h000100, 16'h0040, 16'hBEEF, 1'b0);
        start_req(22'h000100, 16'hBEEF, 1'b1, 1'b0);
        chk("prog_busy", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        addr = 22'h003333; wdata = 16'h1234; prog_req = 1'b1;
        @(negedge clk);
        prog_req = 1'b0;
        wait_done("prog");
        chk("prog_error", {31'd0, error}, 32'd0);
        chk("prog_sr", {24'd0, sr_out}, 32'h80);
        chk("prog_polls", oe_cnt - oe_base, 32'd32);
        chk("prog_addr_held", {9'd0, flash_addr}, 32'h000200);
        repeat (40) @(negedge clk);
        chk("ignored_req_idle", {31'd0, busy}, 32'd0);

        // Status error: clear-SR issued before read-array
        sr_final = 8'h90; ready_after = 4;
        push_seq(22'h000ABC, 16'h0040, 16'h5A5A, 1'b1);
        start_req(22'h000ABC, 16'h5A5A, 1'b1, 1'b0);
        wait_done("srerr");
        chk("srerr_error", {31'd0, error}, 32'd1);
        chk("srerr_sr", {24'd0, sr_out}, 32'h90);

        // Timeout: status never ready, five samples then clear
        sr_final = 8'h80; ready_after = 1000000;
        push_seq(22'h000010, 16'h0040, 16'h0F0F, 1'b1);
        start_req(22'h000010, 16'h0F0F, 1'b1, 1'b0);
        chk("error_cleared_on_accept", {31'd0, error}, 32'd0);
        wait_done("timeout");
        chk("timeout_error", {31'd0, error}, 32'd1);
        chk("timeout_sr", {24'd0, sr_out}, 32'h00);
        chk("timeout_polls", oe_cnt - oe_base, 32'd40);

        // Program and erase in the same cycle: program runs
        sr_final = 8'h80; ready_after = 4;
        push_seq(22'h000777, 16'h0040, 16'hC3C3, 1'b0);
        start_req(22'h000777, 16'hC3C3, 1'b1, 1'b1);
        wait_done("both");
        chk("both_error", {31'd0, error}, 32'd0);

`ifdef FLASH_ERASE_EN
        push_seq(22'h010000, 16'h0020, 16'h00D0, 1'b0);
        start_req(22'h010000, 16'hFFFF, 1'b0, 1'b1);
        chk("erase_busy", {31'd0, busy}, 32'd1);
        wait_done("erase");
        chk("erase_sr", {24'd0, sr_out}, 32'h80);
        chk("erase_error", {31'd0, error}, 32'd0);
`else
        start_req(22'h010000, 16'hFFFF, 1'b0, 1'b1);
        chk("erase_ignored_busy", {31'd0, busy}, 32'd0);
        repeat (30) @(negedge clk);
        chk("erase_ignored_later", {31'd0, busy}, 32'd0);
`endif

        // Reset while polling
        sr_final = 8'h80; ready_after = 1000000;
        exp_q.push_back('{a: 23'h000AAA, d: 16'h0040});
        exp_q.push_back('{a: 23'h000AAA, d: 16'h6666});
        start_req(22'h000555, 16'h6666, 1'b1, 1'b0);
        n = 0;
        while (flash_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reached_poll", {31'd0, flash_oe}, 32'd0);
        dc = done_cnt;
        #2 rst = 1'b0;
        #1;
        chk("midrst_oe", {31'd0, flash_oe}, 32'd1);
        chk("midrst_we", {31'd0, flash_we}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_addr", {9'd0, flash_addr}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("midrst_no_done", done_cnt, dc);
        chk("midrst_sb", exp_q.size(), 32'd0);

        // Normal program after reset release
        ready_after = 8 + 4;
        push_seq(22'h002000, 16'h0040, 16'h9999, 1'b0);
        start_req(22'h002000, 16'h9999, 1'b1, 1'b0);
        wait_done("after_rst");
        chk("after_rst_error", {31'd0, error}, 32'd0);
        chk("after_rst_polls", oe_cnt - oe_base, 32'd16);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
